// File: rtl/matmul_operand_loader.sv
// matmul_operand_loader
//   Feeds the matmul engine. A shape descriptor (n, m, q) is validated, then
//   mat1 (n x m) and mat2 (m x q) are captured from a row-major element
//   stream. The loader checks the stream length and pulses mm_start, then
//   serves the engine through a registered read port until mm_done arrives.
//   Malformed jobs end in a sticky ERR state and never reach the engine.
//
// Optional feature macro: MATMUL_LOADER_IDENTITY_EN
//   When defined, adds input i_cfg_ident. An identity job requires m == q.
//   Such a job skips the mat2 stream, and mat2 reads return the identity
//   matrix within the m x m shape.
//
// Ports
//   i_clk, i_reset               clock, synchronous active-low reset
//   i_cfg_valid / o_cfg_ready    shape handshake, i_cfg_n/m/q dimensions
//   i_in_valid / o_in_ready      element stream, i_in_data, i_in_last
//   o_mm_start, i_mm_done        engine start pulse / completion pulse
//   o_mm_n/m/q                   latched shape
//   i_mm_rd_sel/row/col          read address (sel 0 = mat1, 1 = mat2)
//   o_mm_rd_data                 read data, one cycle latency
//   o_busy, o_err, o_err_code    status
module matmul_operand_loader #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_DIM    = 256,
  localparam int unsigned DW        = $clog2(MAX_DIM + 1),
  localparam int unsigned AW        = $clog2(MAX_DIM)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_cfg_valid,
  output logic                  o_cfg_ready,
  input  logic [DW-1:0]         i_cfg_n,
  input  logic [DW-1:0]         i_cfg_m,
  input  logic [DW-1:0]         i_cfg_q,
`ifdef MATMUL_LOADER_IDENTITY_EN
  input  logic                  i_cfg_ident,
`endif
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  input  logic                  i_in_last,
  output logic                  o_mm_start,
  input  logic                  i_mm_done,
  output logic [DW-1:0]         o_mm_n,
  output logic [DW-1:0]         o_mm_m,
  output logic [DW-1:0]         o_mm_q,
  input  logic                  i_mm_rd_sel,
  input  logic [AW-1:0]         i_mm_rd_row,
  input  logic [AW-1:0]         i_mm_rd_col,
  output logic [DATA_WIDTH-1:0] o_mm_rd_data,
  output logic                  o_busy,
  output logic                  o_err,
  output logic [1:0]            o_err_code
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_RUN    = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_ZERO  = 2'd1;
  localparam logic [1:0] ERR_SHAPE = 2'd2;
  localparam logic [1:0] ERR_LEN   = 2'd3;

  state_t                r_state;
  state_t                w_state_nxt;

  logic                  r_cfg_ready;
  logic                  r_in_ready;
  logic                  r_mm_start;
  logic                  r_busy;
  logic                  r_err;
  logic [1:0]            r_err_code;
  logic [DW-1:0]         r_n;
  logic [DW-1:0]         r_m;
  logic [DW-1:0]         r_q;
  logic [DW-1:0]         r_row;
  logic [DW-1:0]         r_col;
  logic [DATA_WIDTH-1:0] r_rd_data;
`ifdef MATMUL_LOADER_IDENTITY_EN
  logic                  r_ident;
`endif

  logic [DATA_WIDTH-1:0] r_mat1 [MAX_DIM][MAX_DIM];
  logic [DATA_WIDTH-1:0] r_mat2 [MAX_DIM][MAX_DIM];

  logic                  w_cfg_hs;
  logic                  w_in_hs;
  logic [1:0]            w_cfg_code;
  logic [1:0]            w_err_code_nxt;
  logic                  w_latch;
  logic                  w_start_nxt;
  logic [DW-1:0]         w_rows;
  logic [DW-1:0]         w_cols;
  logic                  w_col_wrap;
  logic                  w_final;
  logic [DW-1:0]         w_row_nxt;
  logic [DW-1:0]         w_col_nxt;
  logic                  w_wr_a;
  logic                  w_wr_b;
  logic [DW-1:0]         w_rd_rows;
  logic [DW-1:0]         w_rd_cols;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_cfg_hs = i_cfg_valid & r_cfg_ready;
  assign w_in_hs  = i_in_valid & r_in_ready;

  // Shape validation: zero dimensions take priority over oversize/illegal
  always_comb begin
    w_cfg_code = ERR_NONE;
    if ((i_cfg_n == '0) || (i_cfg_m == '0) || (i_cfg_q == '0)) begin
      w_cfg_code = ERR_ZERO;
    end else if ((i_cfg_n > DW'(MAX_DIM)) || (i_cfg_m > DW'(MAX_DIM)) ||
                 (i_cfg_q > DW'(MAX_DIM))) begin
      w_cfg_code = ERR_SHAPE;
`ifdef MATMUL_LOADER_IDENTITY_EN
    end else if (i_cfg_ident && (i_cfg_m != i_cfg_q)) begin
      w_cfg_code = ERR_SHAPE;
`endif
    end
  end

  // Position of the current beat within the matrix being loaded
  always_comb begin
    w_rows     = (r_state == S_LOAD_B) ? r_m : r_n;
    w_cols     = (r_state == S_LOAD_B) ? r_q : r_m;
    w_col_wrap = (r_col == w_cols - DW'(1));
    w_final    = w_col_wrap && (r_row == w_rows - DW'(1));
  end

  // Next-state and control decode
  always_comb begin
    w_state_nxt    = r_state;
    w_err_code_nxt = r_err_code;
    w_latch        = 1'b0;
    w_start_nxt    = 1'b0;
    w_row_nxt      = r_row;
    w_col_nxt      = r_col;
    w_wr_a         = 1'b0;
    w_wr_b         = 1'b0;

    case (r_state)
      S_IDLE, S_ERR: begin
        // In ERR any beat is discarded; a cfg handshake always takes priority
        if (w_cfg_hs) begin
          w_err_code_nxt = w_cfg_code;
          if (w_cfg_code != ERR_NONE) begin
            w_state_nxt = S_ERR;
          end else begin
            w_state_nxt = S_LOAD_A;
            w_latch     = 1'b1;
            w_row_nxt   = '0;
            w_col_nxt   = '0;
          end
        end
      end

      S_LOAD_A, S_LOAD_B: begin
        if (w_in_hs) begin
          w_wr_a = (r_state == S_LOAD_A);
          w_wr_b = (r_state == S_LOAD_B);
          if (w_col_wrap) begin
            w_col_nxt = '0;
            w_row_nxt = r_row + DW'(1);
          end else begin
            w_col_nxt = r_col + DW'(1);
          end
          if (i_in_last != w_final) begin
            w_state_nxt    = S_ERR;
            w_err_code_nxt = ERR_LEN;
            w_row_nxt      = '0;
            w_col_nxt      = '0;
          end else if (w_final) begin
            w_row_nxt = '0;
            w_col_nxt = '0;
            if (r_state == S_LOAD_B) begin
              w_state_nxt = S_RUN;
              w_start_nxt = 1'b1;
            end else begin
`ifdef MATMUL_LOADER_IDENTITY_EN
              if (r_ident) begin
                w_state_nxt = S_RUN;
                w_start_nxt = 1'b1;
              end else begin
                w_state_nxt = S_LOAD_B;
              end
`else
              w_state_nxt = S_LOAD_B;
`endif
            end
          end
        end
      end

      S_RUN: begin
        if (i_mm_done) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Read mux; addresses outside the latched shape return zero
  always_comb begin
    w_rd_rows = i_mm_rd_sel ? r_m : r_n;
    w_rd_cols = i_mm_rd_sel ? r_q : r_m;
    w_rd_data = '0;
    if ((DW'(i_mm_rd_row) < w_rd_rows) && (DW'(i_mm_rd_col) < w_rd_cols)) begin
      if (!i_mm_rd_sel) begin
        w_rd_data = r_mat1[i_mm_rd_row][i_mm_rd_col];
`ifdef MATMUL_LOADER_IDENTITY_EN
      end else if (r_ident) begin
        w_rd_data = (i_mm_rd_row == i_mm_rd_col) ? DATA_WIDTH'(1) : '0;
`endif
      end else begin
        w_rd_data = r_mat2[i_mm_rd_row][i_mm_rd_col];
      end
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered outputs, shape, counters; status is decoded from the next state
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_cfg_ready <= 1'b0;
      r_in_ready  <= 1'b0;
      r_mm_start  <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_n         <= '0;
      r_m         <= '0;
      r_q         <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_rd_data   <= '0;
`ifdef MATMUL_LOADER_IDENTITY_EN
      r_ident     <= 1'b0;
`endif
    end else begin
      r_cfg_ready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_ERR);
      r_in_ready  <= (w_state_nxt == S_LOAD_A) || (w_state_nxt == S_LOAD_B) ||
                     (w_state_nxt == S_ERR);
      r_busy      <= (w_state_nxt == S_LOAD_A) || (w_state_nxt == S_LOAD_B) ||
                     (w_state_nxt == S_RUN);
      r_err       <= (w_state_nxt == S_ERR);
      r_mm_start  <= w_start_nxt;
      r_err_code  <= w_err_code_nxt;
      r_row       <= w_row_nxt;
      r_col       <= w_col_nxt;
      r_rd_data   <= w_rd_data;
      if (w_latch) begin
        r_n <= i_cfg_n;
        r_m <= i_cfg_m;
        r_q <= i_cfg_q;
`ifdef MATMUL_LOADER_IDENTITY_EN
        r_ident <= i_cfg_ident;
`endif
      end
    end
  end

  // Operand buffers; contents survive reset
  always_ff @(posedge i_clk) begin
    if (i_reset && w_wr_a) begin
      r_mat1[r_row[AW-1:0]][r_col[AW-1:0]] <= i_in_data;
    end
    if (i_reset && w_wr_b) begin
      r_mat2[r_row[AW-1:0]][r_col[AW-1:0]] <= i_in_data;
    end
  end

  assign o_cfg_ready  = r_cfg_ready;
  assign o_in_ready   = r_in_ready;
  assign o_mm_start   = r_mm_start;
  assign o_busy       = r_busy;
  assign o_err        = r_err;
  assign o_err_code   = r_err_code;
  assign o_mm_n       = r_n;
  assign o_mm_m       = r_m;
  assign o_mm_q       = r_q;
  assign o_mm_rd_data = r_rd_data;

endmodule

// File: tb/tb_matmul_operand_loader.sv
// Directed bench for matmul_operand_loader (default parameters).
module tb_matmul_operand_loader;
  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned DW = 9;
  localparam int unsigned AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset;
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [DW-1:0]         cfg_n, cfg_m, cfg_q;
`ifdef MATMUL_LOADER_IDENTITY_EN
  logic                  cfg_ident;
`endif
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  mm_start;
  logic                  mm_done;
  logic [DW-1:0]         mm_n, mm_m, mm_q;
  logic                  rd_sel;
  logic [AW-1:0]         rd_row, rd_col;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  busy;
  logic                  err;
  logic [1:0]            err_code;

  int errors = 0;
  int checks = 0;

  matmul_operand_loader dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_cfg_valid  (cfg_valid),
    .o_cfg_ready  (cfg_ready),
    .i_cfg_n      (cfg_n),
    .i_cfg_m      (cfg_m),
    .i_cfg_q      (cfg_q),
`ifdef MATMUL_LOADER_IDENTITY_EN
    .i_cfg_ident  (cfg_ident),
`endif
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_in_data    (in_data),
    .i_in_last    (in_last),
    .o_mm_start   (mm_start),
    .i_mm_done    (mm_done),
    .o_mm_n       (mm_n),
    .o_mm_m       (mm_m),
    .o_mm_q       (mm_q),
    .i_mm_rd_sel  (rd_sel),
    .i_mm_rd_row  (rd_row),
    .i_mm_rd_col  (rd_col),
    .o_mm_rd_data (rd_data),
    .o_busy       (busy),
    .o_err        (err),
    .o_err_code   (err_code)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input int n, input int m, input int q);
    cfg_valid = 1'b1;
    cfg_n = DW'(n);
    cfg_m = DW'(m);
    cfg_q = DW'(q);
`ifdef MATMUL_LOADER_IDENTITY_EN
    cfg_ident = 1'b0;
`endif
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic beat(input logic [DATA_WIDTH-1:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    cyc();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulse_done();
    mm_done = 1'b1;
    cyc();
    mm_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cyc();
    cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %0b want 0", err); end
    checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL rst_err_code: got %0d want 0", err_code); end
    checks++; if (mm_start !== 1'b0) begin errors++; $display("FAIL rst_mm_start: got %0b want 0", mm_start); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
    checks++; if ({mm_n, mm_m, mm_q} !== 27'd0) begin errors++; $display("FAIL rst_shape: got %0d %0d %0d want 0 0 0", mm_n, mm_m, mm_q); end
    checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL rst_rd_data: got %h want 0000", rd_data); end
    reset = 1'b1;
    cyc();
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_cfg_ready: got %0b want 1", cfg_ready); end
  endtask

  task automatic test_bad_cfg();
    do_cfg(0, 5, 3);
    checks++; if (err !== 1'b1 || err_code !== 2'd1) begin errors++; $display("FAIL zero_dim: got err=%0b code=%0d want err=1 code=1", err, err_code); end
    checks++; if (mm_start !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_dim_idle: got start=%0b busy=%0b want 0 0", mm_start, busy); end
    checks++; if (cfg_ready !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL err_ready: got cfg=%0b in=%0b want 1 1", cfg_ready, in_ready); end
    do_cfg(257, 5, 3);
    checks++; if (err_code !== 2'd2) begin errors++; $display("FAIL oversize_n: got %0d want 2", err_code); end
    do_cfg(4, 4, 511);
    checks++; if (err_code !== 2'd2) begin errors++; $display("FAIL oversize_q: got %0d want 2", err_code); end
    do_cfg(0, 300, 1);
    checks++; if (err_code !== 2'd1) begin errors++; $display("FAIL zero_over_priority: got %0d want 1", err_code); end
  endtask

  task automatic test_normal();
    logic [DATA_WIDTH-1:0] ea [30];
    logic [DATA_WIDTH-1:0] eb [15];
    for (int i = 0; i < 30; i++) ea[i] = DATA_WIDTH'(i * 3 - 40);
    for (int i = 0; i < 15; i++) eb[i] = DATA_WIDTH'(100 - 7 * i);
    do_cfg(6, 5, 3);
    checks++; if (err !== 1'b0 || err_code !== 2'd0 || busy !== 1'b1) begin errors++; $display("FAIL cfg_accept: got err=%0b code=%0d busy=%0b want 0 0 1", err, err_code, busy); end
    checks++; if (in_ready !== 1'b1 || cfg_ready !== 1'b0) begin errors++; $display("FAIL load_ready: got in=%0b cfg=%0b want 1 0", in_ready, cfg_ready); end
    for (int i = 0; i < 30; i++) beat(ea[i], i == 29);
    checks++; if (busy !== 1'b1 || err !== 1'b0 || mm_start !== 1'b0) begin errors++; $display("FAIL after_mat1: got busy=%0b err=%0b start=%0b want 1 0 0", busy, err, mm_start); end
    for (int i = 0; i < 14; i++) beat(eb[i], 1'b0);
    checks++; if (mm_start !== 1'b0) begin errors++; $display("FAIL start_early: got %0b want 0", mm_start); end
    beat(eb[14], 1'b1);
    checks++; if (mm_start !== 1'b1) begin errors++; $display("FAIL start_pulse: got %0b want 1", mm_start); end
    checks++; if (in_ready !== 1'b0 || cfg_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL run_flags: got in=%0b cfg=%0b busy=%0b want 0 0 1", in_ready, cfg_ready, busy); end
    cyc();
    checks++; if (mm_start !== 1'b0) begin errors++; $display("FAIL start_one_cycle: got %0b want 0", mm_start); end
    checks++; if (mm_n !== 9'd6 || mm_m !== 9'd5 || mm_q !== 9'd3) begin errors++; $display("FAIL shape: got %0d %0d %0d want 6 5 3", mm_n, mm_m, mm_q); end
    rd_sel = 1'b0;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 5; c++) begin
        rd_row = AW'(r); rd_col = AW'(c);
        cyc();
        checks++; if (rd_data !== ea[r*5+c]) begin errors++; $display("FAIL rd_mat1[%0d][%0d]: got %h want %h", r, c, rd_data, ea[r*5+c]); end
      end
    end
    rd_sel = 1'b1;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 3; c++) begin
        rd_row = AW'(r); rd_col = AW'(c);
        cyc();
        checks++; if (rd_data !== eb[r*3+c]) begin errors++; $display("FAIL rd_mat2[%0d][%0d]: got %h want %h", r, c, rd_data, eb[r*3+c]); end
      end
    end
    rd_sel = 1'b0; rd_row = 8'd6; rd_col = 8'd0;
    cyc();
    checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL rd_oob_row: got %h want 0000", rd_data); end
    rd_sel = 1'b1; rd_row = 8'd0; rd_col = 8'd3;
    cyc();
    checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL rd_oob_col: got %h want 0000", rd_data); end
    pulse_done();
    checks++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin errors++; $display("FAIL done_idle: got busy=%0b cfg=%0b want 0 1", busy, cfg_ready); end
    rd_sel = 1'b0; rd_row = 8'd5; rd_col = 8'd4;
    cyc();
    checks++; if (rd_data !== ea[29]) begin errors++; $display("FAIL rd_after_done: got %h want %h", rd_data, ea[29]); end
  endtask

  task automatic test_early_last();
    do_cfg(2, 2, 2);
    beat(16'd1, 1'b0);
    beat(16'd2, 1'b0);
    beat(16'd3, 1'b1);
    checks++; if (err_code !== 2'd3 || busy !== 1'b0 || err !== 1'b1) begin errors++; $display("FAIL early_last: got code=%0d busy=%0b err=%0b want 3 0 1", err_code, busy, err); end
    do_cfg(1, 1, 1);
    checks++; if (err !== 1'b0 || err_code !== 2'd0) begin errors++; $display("FAIL err_clear: got err=%0b code=%0d want 0 0", err, err_code); end
    beat(16'd7, 1'b1);
    beat(16'hFFFE, 1'b1);
    checks++; if (mm_start !== 1'b1) begin errors++; $display("FAIL one_by_one_start: got %0b want 1", mm_start); end
    rd_sel = 1'b0; rd_row = 8'd0; rd_col = 8'd0;
    cyc();
    checks++; if (rd_data !== 16'd7) begin errors++; $display("FAIL one_rd_sel0: got %h want 0007", rd_data); end
    rd_sel = 1'b1;
    cyc();
    checks++; if (rd_data !== 16'hFFFE) begin errors++; $display("FAIL one_rd_sel1: got %h want fffe", rd_data); end
    pulse_done();
    do_cfg(1, 1, 1);
    beat(16'd4, 1'b0);
    checks++; if (err_code !== 2'd3 || err !== 1'b1) begin errors++; $display("FAIL missing_last: got code=%0d err=%0b want 3 1", err_code, err); end
  endtask

  task automatic test_err_cfg_wins();
    // cfg and a beat in the same ERR cycle: the beat must be dropped
    cfg_valid = 1'b1; cfg_n = 9'd1; cfg_m = 9'd1; cfg_q = 9'd1;
`ifdef MATMUL_LOADER_IDENTITY_EN
    cfg_ident = 1'b0;
`endif
    in_valid = 1'b1; in_data = 16'd99; in_last = 1'b1;
    cyc();
    cfg_valid = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    checks++; if (busy !== 1'b1 || err !== 1'b0 || err_code !== 2'd0) begin errors++; $display("FAIL cfg_wins: got busy=%0b err=%0b code=%0d want 1 0 0", busy, err, err_code); end
    beat(16'd5, 1'b1);
    checks++; if (mm_start !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL beat_dropped: got start=%0b busy=%0b want 0 1", mm_start, busy); end
    beat(16'd9, 1'b1);
    checks++; if (mm_start !== 1'b1) begin errors++; $display("FAIL cfg_wins_start: got %0b want 1", mm_start); end
    rd_sel = 1'b0; rd_row = 8'd0; rd_col = 8'd0;
    cyc();
    checks++; if (rd_data !== 16'd5) begin errors++; $display("FAIL cfg_wins_rd: got %h want 0005", rd_data); end
    pulse_done();
  endtask

  task automatic test_reset_mid_load();
    logic start_seen;
    start_seen = 1'b0;
    do_cfg(2, 3, 2);
    for (int i = 0; i < 6; i++) beat(DATA_WIDTH'(i + 1), i == 5);
    beat(16'd20, 1'b0);
    beat(16'd21, 1'b0);
    reset = 1'b0;
    cyc();
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || mm_start !== 1'b0) begin errors++; $display("FAIL rst_mid_b: got busy=%0b in=%0b start=%0b want 0 0 0", busy, in_ready, mm_start); end
    reset = 1'b1;
    cyc();
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_b_ready: got %0b want 1", cfg_ready); end
    for (int i = 0; i < 4; i++) begin
      beat(DATA_WIDTH'(22 + i), i == 3);
      start_seen = start_seen | mm_start;
    end
    checks++; if (start_seen !== 1'b0) begin errors++; $display("FAIL rst_mid_b_nostart: got %0b want 0", start_seen); end
    pulse_done();
    checks++; if (busy !== 1'b0 || cfg_ready !== 1'b1 || mm_n !== 9'd0) begin errors++; $display("FAIL rst_mid_b_done: got busy=%0b cfg=%0b n=%0d want 0 1 0", busy, cfg_ready, mm_n); end

    do_cfg(256, 256, 256);
    checks++; if (err !== 1'b0 || busy !== 1'b1 || mm_n !== 9'd256) begin errors++; $display("FAIL max_dim_accept: got err=%0b busy=%0b n=%0d want 0 1 256", err, busy, mm_n); end
    for (int i = 0; i < 10; i++) beat(DATA_WIDTH'(i), 1'b0);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    pulse_done();
    checks++; if (busy !== 1'b0 || mm_start !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL max_dim_reset: got busy=%0b start=%0b err=%0b want 0 0 0", busy, mm_start, err); end
  endtask

  task automatic test_backpressure();
    logic [DATA_WIDTH-1:0] exp;
    do_cfg(3, 2, 2);
    for (int i = 0; i < 10; i++) begin
      while ($urandom_range(0, 1) == 1) begin
        // idle cycle with garbage; mm_done here must be ignored in LOAD_A
        in_valid = 1'b0; in_data = 16'hDEAD; in_last = 1'b1;
        mm_done = (i < 6);
        cyc();
        mm_done = 1'b0; in_last = 1'b0;
      end
      if (i < 6) beat(DATA_WIDTH'(16'h1000 + i), i == 5);
      else       beat(DATA_WIDTH'(16'h2000 + i - 6), i == 9);
      if (i == 5) begin
        checks++; if (busy !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL bp_mat1: got busy=%0b err=%0b want 1 0", busy, err); end
      end
    end
    checks++; if (mm_start !== 1'b1) begin errors++; $display("FAIL bp_start: got %0b want 1", mm_start); end
    for (int i = 0; i < 10; i++) begin
      rd_sel = (i >= 6);
      rd_row = (i < 6) ? AW'(i / 2) : AW'((i - 6) / 2);
      rd_col = (i < 6) ? AW'(i % 2) : AW'((i - 6) % 2);
      exp    = (i < 6) ? DATA_WIDTH'(16'h1000 + i) : DATA_WIDTH'(16'h2000 + i - 6);
      cyc();
      checks++; if (rd_data !== exp) begin errors++; $display("FAIL bp_rd[%0d]: got %h want %h", i, rd_data, exp); end
    end
    pulse_done();
  endtask

`ifdef MATMUL_LOADER_IDENTITY_EN
  task automatic test_identity();
    cfg_valid = 1'b1; cfg_n = 9'd4; cfg_m = 9'd4; cfg_q = 9'd4; cfg_ident = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    for (int i = 0; i < 16; i++) beat(DATA_WIDTH'(i), i == 15);
    checks++; if (mm_start !== 1'b1) begin errors++; $display("FAIL ident_start: got %0b want 1", mm_start); end
    rd_sel = 1'b1; rd_row = 8'd2; rd_col = 8'd2;
    cyc();
    checks++; if (rd_data !== 16'd1) begin errors++; $display("FAIL ident_diag: got %h want 0001", rd_data); end
    rd_col = 8'd3;
    cyc();
    checks++; if (rd_data !== 16'd0) begin errors++; $display("FAIL ident_off: got %h want 0000", rd_data); end
    pulse_done();
    cfg_valid = 1'b1; cfg_n = 9'd4; cfg_m = 9'd4; cfg_q = 9'd3; cfg_ident = 1'b1;
    cyc();
    cfg_valid = 1'b0; cfg_ident = 1'b0;
    checks++; if (err_code !== 2'd2) begin errors++; $display("FAIL ident_shape: got %0d want 2", err_code); end
  endtask
`endif

  initial begin
    reset = 1'b0; cfg_valid = 1'b0; cfg_n = '0; cfg_m = '0; cfg_q = '0;
`ifdef MATMUL_LOADER_IDENTITY_EN
    cfg_ident = 1'b0;
`endif
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; mm_done = 1'b0;
    rd_sel = 1'b0; rd_row = '0; rd_col = '0;
    test_reset();
    test_bad_cfg();
    test_normal();
    test_early_last();
    test_err_cfg_wins();
    test_reset_mid_load();
    test_backpressure();
`ifdef MATMUL_LOADER_IDENTITY_EN
    test_identity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
